// File: rtl/gmii_log_rx_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gmii_log_rx_mux: round-robin packer of N GMII capture FIFOs into one     |
// | USB bulk IN buffer, one packet (header, metadata, data) per commit.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gmii_log_rx_mux #(
    parameter int CHANNELS   = 2,
    parameter int META_BYTES = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [CHANNELS-1:0]               available,
    input  logic [CHANNELS*META_BYTES*8-1:0]  meta,
    output logic [CHANNELS-1:0]               meta_en,
    input  logic [CHANNELS*8-1:0]             data,
    input  logic [CHANNELS-1:0]               data_stop,
    output logic [CHANNELS-1:0]               data_en,
    output logic [ADDR_WIDTH-1:0]             usb_in_addr,
    output logic [7:0]                        usb_in_data,
    output logic                              usb_in_wren,
    input  logic                              usb_in_ready,
    output logic                              usb_in_commit,
    output logic [ADDR_WIDTH:0]               usb_in_commit_len,
    input  logic                              usb_in_commit_ack,
    output logic [15:0]                       drop_count
);

    localparam int c_gw = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_mw = META_BYTES * 8;
    localparam logic [ADDR_WIDTH:0] c_cap      = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_data_org = (ADDR_WIDTH+1)'(META_BYTES + 1);
    localparam logic [c_gw-1:0]     c_last_rst = c_gw'(CHANNELS - 1);
    localparam logic [4:0]          c_meta_end = 5'(META_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_META_WAIT = 3'd1,
        S_META      = 3'd2,
        S_DATA_WAIT = 3'd3,
        S_DATA      = 3'd4,
        S_HEADER    = 3'd5,
        S_COMMIT    = 3'd6,
        S_WAIT      = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [c_gw-1:0]         grant_q, grant_d;
    logic [c_gw-1:0]         last_grant_q, last_grant_d;
    logic [4:0]              meta_cnt_q, meta_cnt_d;
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic                    trunc_q, trunc_d;
    logic [15:0]             drop_count_q, drop_count_d;
    logic [CHANNELS-1:0]     meta_en_q, meta_en_d;
    logic [CHANNELS-1:0]     data_en_q, data_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    wren_q, wren_d;
    logic                    commit_q, commit_d;
    logic [ADDR_WIDTH:0]     commit_len_q, commit_len_d;

    logic                    arb_found;
    logic [c_gw-1:0]         arb_idx;
    logic [c_mw-1:0]         meta_word;
    logic [7:0]              cur_data;
    logic                    cur_stop;

    assign meta_word = meta[int'(grant_q)*c_mw +: c_mw];
    assign cur_data  = data[int'(grant_q)*8 +: 8];
    assign cur_stop  = data_stop[grant_q];

    // Rotating-priority search starting just after the last served channel.
    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!arb_found && available[idx]) begin
                arb_found = 1'b1;
                arb_idx   = c_gw'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        meta_cnt_d   = meta_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        trunc_d      = trunc_q;
        drop_count_d = drop_count_q;
        meta_en_d    = '0;
        data_en_d    = '0;
        addr_d       = '0;
        wdata_d      = '0;
        wren_d       = 1'b0;
        commit_d     = 1'b0;
        commit_len_d = '0;

        case (state_q)
            S_IDLE: begin
                if (usb_in_ready && (|available) && arb_found) begin
                    grant_d            = arb_idx;
                    meta_en_d[arb_idx] = 1'b1;
                    meta_cnt_d         = '0;
                    state_d            = S_META_WAIT;
                end
            end
            S_META_WAIT: begin
                state_d = S_META;
            end
            S_META: begin
                addr_d  = ADDR_WIDTH'(meta_cnt_q) + ADDR_WIDTH'(1);
                wdata_d = meta_word[(META_BYTES-1-int'(meta_cnt_q))*8 +: 8];
                wren_d  = 1'b1;
                if (meta_cnt_q == c_meta_end) begin
                    data_en_d[grant_q] = 1'b1;
                    wr_ptr_d           = c_data_org;
                    state_d            = S_DATA_WAIT;
                end else begin
                    meta_cnt_d = meta_cnt_q + 5'd1;
                end
            end
            S_DATA_WAIT: begin
                data_en_d[grant_q] = 1'b1;
                state_d            = S_DATA;
            end
            S_DATA: begin
                // Bytes beyond the buffer are still consumed so the source drains to its stop marker.
                if (wr_ptr_q < c_cap) begin
                    addr_d   = wr_ptr_q[ADDR_WIDTH-1:0];
                    wdata_d  = cur_data;
                    wren_d   = 1'b1;
                    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
                end else begin
                    trunc_d = 1'b1;
                end
                if (cur_stop) begin
                    state_d = S_HEADER;
                end else begin
                    data_en_d[grant_q] = 1'b1;
                end
            end
            S_HEADER: begin
                addr_d  = '0;
                wdata_d = {trunc_q, 1'b0, 6'(grant_q)};
                wren_d  = 1'b1;
                if (trunc_q && (drop_count_q != 16'hFFFF)) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (commit_q && usb_in_commit_ack) begin
                    state_d = S_WAIT;
                end else begin
                    commit_d     = 1'b1;
                    commit_len_d = wr_ptr_q;
                end
            end
            S_WAIT: begin
                if (!usb_in_commit_ack) begin
                    trunc_d      = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= c_last_rst;
            meta_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            trunc_q      <= 1'b0;
            drop_count_q <= '0;
            meta_en_q    <= '0;
            data_en_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            commit_q     <= 1'b0;
            commit_len_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            meta_cnt_q   <= meta_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            trunc_q      <= trunc_d;
            drop_count_q <= drop_count_d;
            meta_en_q    <= meta_en_d;
            data_en_q    <= data_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wren_q       <= wren_d;
            commit_q     <= commit_d;
            commit_len_q <= commit_len_d;
        end
    end

    // The read enable must fall in the very cycle the stop byte is presented,
    // otherwise the FIFO would be popped once past the end of the packet.
    assign data_en           = ((state_q == S_DATA) && cur_stop) ? '0 : data_en_q;
    assign meta_en           = meta_en_q;
    assign usb_in_addr       = addr_q;
    assign usb_in_data       = wdata_q;
    assign usb_in_wren       = wren_q;
    assign usb_in_commit     = commit_q;
    assign usb_in_commit_len = commit_len_q;
    assign drop_count        = drop_count_q;

endmodule
`default_nettype wire
